// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, mcause codes, CSR op encoding, FSM states and bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_EXT_IRQ   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL   = 32'h0000_0002;
  localparam logic [31:0] CAUSE_ECALL     = 32'h0000_000B;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;

  typedef enum logic [1:0] {
    CSR_OP_RW   = 2'b00,
    CSR_OP_RS   = 2'b01,
    CSR_OP_RC   = 2'b10,
    CSR_OP_NONE = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } trap_state_e;

endpackage

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational read mux, RW/RS/RC write path and
// the trap-entry / MRET side-effect port driven by the trap sequencer.
module csr_regfile
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic            wr_en,
  input  csr_op_e         op,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret_en,
  input  logic            ext_irq,
  input  logic            timer_irq,
  output logic            mstatus_mie,
  output logic            mie_meie,
  output logic            mie_mtie,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc
);

  logic            mie_q, mpie_q, meie_q, mtie_q;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q;
  logic [XLEN-1:0] old_val, new_val;
  logic            wr_hit;

  always_comb begin
    old_val = '0;
    unique case (addr)
      CSR_MSTATUS: begin
        old_val[MSTATUS_MIE_BIT]  = mie_q;
        old_val[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MIE: begin
        old_val[MIE_MTIE_BIT] = mtie_q;
        old_val[MIE_MEIE_BIT] = meie_q;
      end
      CSR_MTVEC:  old_val = mtvec_q;
      CSR_MEPC:   old_val = mepc_q;
      CSR_MCAUSE: old_val = mcause_q;
      CSR_MIP: begin
        old_val[MIE_MTIE_BIT] = timer_irq;
        old_val[MIE_MEIE_BIT] = ext_irq;
      end
      default:    old_val = '0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    unique case (op)
      CSR_OP_RW: new_val = wdata;
      CSR_OP_RS: new_val = old_val | wdata;
      CSR_OP_RC: new_val = old_val & ~wdata;
      default:   new_val = old_val;
    endcase
  end

  assign rdata  = rd_en ? old_val : '0;
  assign wr_hit = wr_en && (op != CSR_OP_NONE);

  // Trap entry and MRET take precedence; the top never asserts them with wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap_en) begin
      mepc_q   <= trap_epc & ~XLEN'(3);
      mcause_q <= trap_cause;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (mret_en) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_hit) begin
      unique case (addr)
        CSR_MSTATUS: begin
          mie_q  <= new_val[MSTATUS_MIE_BIT];
          mpie_q <= new_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          mtie_q <= new_val[MIE_MTIE_BIT];
          meie_q <= new_val[MIE_MEIE_BIT];
        end
        // Reserved modes 1x collapse to direct.
        CSR_MTVEC:  mtvec_q  <= {new_val[XLEN-1:2], 1'b0, new_val[0] & ~new_val[1]};
        CSR_MEPC:   mepc_q   <= new_val & ~XLEN'(3);
        CSR_MCAUSE: mcause_q <= new_val;
        default: ;
      endcase
    end
  end

  assign mstatus_mie = mie_q;
  assign mie_meie    = meie_q;
  assign mie_mtie    = mtie_q;
  assign mtvec       = mtvec_q;
  assign mepc        = mepc_q;

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file plus trap/interrupt sequencer: prioritises events,
// computes the redirect target and issues a one-cycle redirect + flush.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            csr_rd_en,
  input  logic            csr_wr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic            illegal_instr,
  input  logic            ext_irq,
  input  logic            timer_irq,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_pc,
  output logic            flush
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            mstatus_mie, mie_meie, mie_mtie;
  logic [XLEN-1:0] mtvec, mepc;

  logic            run_valid, take_ext, take_timer, take_ill, take_ecall;
  logic            is_irq, trap_take, mret_take, csr_wr;
  logic [XLEN-1:0] cause, base, trap_target;

  always_comb begin
    run_valid  = (state_q == ST_RUN) && instr_valid;
    take_ext   = run_valid && mstatus_mie && mie_meie && ext_irq;
    take_timer = run_valid && mstatus_mie && mie_mtie && timer_irq && !take_ext;
    is_irq     = take_ext || take_timer;
    take_ill   = run_valid && illegal_instr && !is_irq;
    take_ecall = run_valid && is_ecall && !is_irq && !illegal_instr;
    trap_take  = is_irq || take_ill || take_ecall;
    mret_take  = run_valid && is_mret && !trap_take;
    csr_wr     = run_valid && csr_wr_en && !trap_take && !mret_take;

    cause = XLEN'(CAUSE_ECALL);
    if (take_ext)        cause = XLEN'(CAUSE_EXT_IRQ);
    else if (take_timer) cause = XLEN'(CAUSE_TIMER_IRQ);
    else if (take_ill)   cause = XLEN'(CAUSE_ILLEGAL);

    // Only interrupts are vectored; exceptions always land on the base.
    base        = {mtvec[XLEN-1:2], 2'b00};
    trap_target = base;
    if (is_irq && (mtvec[1:0] == 2'b01))
      trap_target = base + {{(XLEN-6){1'b0}}, cause[3:0], 2'b00};
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      ST_RUN: begin
        if (trap_take) begin
          state_d  = ST_REDIRECT;
          target_d = trap_target;
        end else if (mret_take) begin
          state_d  = ST_REDIRECT;
          target_d = mepc;
        end
      end
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign trap_redirect = (state_q == ST_REDIRECT);
  assign flush         = (state_q == ST_REDIRECT);
  assign trap_pc       = (state_q == ST_REDIRECT) ? target_q : '0;

  csr_regfile #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RESET)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (csr_rd_en),
    .wr_en       (csr_wr),
    .op          (csr_op_e'(csr_op)),
    .addr        (csr_addr),
    .wdata       (csr_wdata),
    .rdata       (csr_rdata),
    .trap_en     (trap_take),
    .trap_epc    (pc),
    .trap_cause  (cause),
    .mret_en     (mret_take),
    .ext_irq     (ext_irq),
    .timer_irq   (timer_irq),
    .mstatus_mie (mstatus_mie),
    .mie_meie    (mie_meie),
    .mie_mtie    (mie_mtie),
    .mtvec       (mtvec),
    .mepc        (mepc)
  );

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: expectations are queued as stimulus is
// driven and popped when the redirect or CSR read-back is observed.
module tb_csr_trap_ctrl;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0200;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
  localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MIP = 12'h344;
  localparam logic [1:0]  OP_RW = 2'b00, OP_RS = 2'b01, OP_RC = 2'b10, OP_NONE = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, csr_rd_en, csr_wr_en;
  logic [31:0] pc, csr_wdata, csr_rdata, trap_pc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic        is_ecall, is_mret, illegal_instr, ext_irq, timer_irq;
  logic        trap_redirect, flush;

  csr_trap_ctrl #(.XLEN(32), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
    .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .is_ecall(is_ecall), .is_mret(is_mret), .illegal_instr(illegal_instr),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .trap_redirect(trap_redirect),
    .trap_pc(trap_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [11:0] addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic idle();
    instr_valid = 0; csr_rd_en = 0; csr_wr_en = 0; csr_op = OP_NONE;
    csr_addr = '0; csr_wdata = '0; is_ecall = 0; is_mret = 0;
    illegal_instr = 0; pc = '0;
  endtask

  task automatic csr_write(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    @(negedge clk);
    idle();
    instr_valid = 1; csr_wr_en = 1; csr_op = op; csr_addr = a; csr_wdata = wd;
    @(negedge clk);
    idle();
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] v);
    instr_valid = 0; csr_wr_en = 0; csr_rd_en = 1; csr_addr = a;
    #1;
    v = csr_rdata;
    csr_rd_en = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    rst = 1; ext_irq = 0; timer_irq = 0; idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    n_cmp++;
    if ({trap_redirect, flush, trap_pc} !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got redir=%b flush=%b pc=%h, want 0 0 0", trap_redirect, flush, trap_pc);
    end
    csr_addr = A_MTVEC; csr_rd_en = 0; #1;
    n_cmp++;
    if (csr_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rdata_no_rd_en: got %h want 0", csr_rdata);
    end
    sb.push_back('{"rst_mstatus", A_MSTATUS, 32'h0});
    sb.push_back('{"rst_mtvec", A_MTVEC, MTVEC_RST});
    sb.push_back('{"rst_mie", A_MIE, 32'h0});
    sb.push_back('{"rst_mepc", A_MEPC, 32'h0});
    sb.push_back('{"rst_mcause", A_MCAUSE, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_csr_ops();
    exp_t e;
    logic [31:0] obs;
    // Back-to-back CSR instructions: each returns the old value in its own cycle.
    @(negedge clk); idle();
    instr_valid = 1; csr_rd_en = 1; csr_wr_en = 1; csr_op = OP_RW; csr_addr = A_MTVEC; csr_wdata = 32'h100;
    #1; n_cmp++;
    if (csr_rdata !== MTVEC_RST) begin n_bad++; $display("FAIL rw_old_mtvec: got %h want %h", csr_rdata, MTVEC_RST); end
    @(negedge clk);
    csr_op = OP_RS; csr_addr = A_MSTATUS; csr_wdata = 32'h8;
    #1; n_cmp++;
    if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL rs_old_mstatus: got %h want 0", csr_rdata); end
    @(negedge clk);
    csr_op = OP_RC; csr_addr = A_MSTATUS; csr_wdata = 32'h8;
    #1; n_cmp++;
    if (csr_rdata !== 32'h8) begin n_bad++; $display("FAIL rc_old_mstatus: got %h want 8", csr_rdata); end
    @(negedge clk); idle();
    sb.push_back('{"mtvec_rw", A_MTVEC, 32'h100});
    sb.push_back('{"mstatus_rc", A_MSTATUS, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
    // Field masking, legalisation, unknown address and reserved op.
    csr_write(OP_RW, A_MIE, 32'hFFFF_FFFF);
    csr_write(OP_RW, A_MSTATUS, 32'hFFFF_FFFF);
    csr_write(OP_RW, A_MEPC, 32'h0000_0047);
    csr_write(OP_RW, A_MCAUSE, 32'h1234_5678);
    csr_write(OP_NONE, A_MCAUSE, 32'h0);
    csr_write(OP_RW, 12'h123, 32'hFFFF);
    csr_write(OP_RW, A_MTVEC, 32'h103);
    @(negedge clk);
    instr_valid = 0; csr_wr_en = 1; csr_op = OP_RW; csr_addr = A_MEPC; csr_wdata = 32'h800;
    @(negedge clk); idle();
    sb.push_back('{"mie_mask", A_MIE, 32'h880});
    sb.push_back('{"mstatus_mask", A_MSTATUS, 32'h88});
    sb.push_back('{"mepc_align", A_MEPC, 32'h44});
    sb.push_back('{"mcause_rsvd_op", A_MCAUSE, 32'h1234_5678});
    sb.push_back('{"unknown_addr", 12'h123, 32'h0});
    sb.push_back('{"mtvec_mode11", A_MTVEC, 32'h100});
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
    csr_write(OP_RC, A_MSTATUS, 32'hFFFF_FFFF);
    @(negedge clk); ext_irq = 1; timer_irq = 0; peek(A_MIP, obs); n_cmp++;
    if (obs !== 32'h800) begin n_bad++; $display("FAIL mip_ext: got %h want 800", obs); end
    @(negedge clk); ext_irq = 0; timer_irq = 1; peek(A_MIP, obs); n_cmp++;
    if (obs !== 32'h80) begin n_bad++; $display("FAIL mip_timer: got %h want 80", obs); end
    timer_irq = 0;
  endtask

  task automatic test_timer_irq();
    exp_t e;
    logic [31:0] obs;
    csr_write(OP_RW, A_MIE, 32'h80);
    csr_write(OP_RW, A_MSTATUS, 32'h8);
    @(negedge clk); idle(); instr_valid = 1; pc = 32'h40; timer_irq = 1;
    sb.push_back('{"timer_trap_pc", 12'h0, 32'h100});
    @(posedge clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (trap_redirect !== 1'b1 || flush !== 1'b1 || trap_pc !== e.val) begin
      n_bad++; $display("FAIL %s: got redir=%b flush=%b pc=%h want 1 1 %h", e.tag, trap_redirect, flush, trap_pc, e.val);
    end
    @(negedge clk); timer_irq = 0; idle();
    @(posedge clk); #1; n_cmp++;
    if (trap_redirect !== 1'b0 || flush !== 1'b0) begin
      n_bad++; $display("FAIL redirect_one_cycle: got redir=%b flush=%b want 0 0", trap_redirect, flush);
    end
    sb.push_back('{"timer_mepc", A_MEPC, 32'h40});
    sb.push_back('{"timer_mcause", A_MCAUSE, 32'h8000_0007});
    sb.push_back('{"timer_mstatus", A_MSTATUS, 32'h80});
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
    csr_write(OP_RW, A_MIE, 32'h880);
    csr_write(OP_RW, A_MSTATUS, 32'h8);
    @(negedge clk); idle(); instr_valid = 1; pc = 32'h50; ext_irq = 1; timer_irq = 1;
    sb.push_back('{"both_trap_pc", 12'h0, 32'h100});
    @(posedge clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (trap_redirect !== 1'b1 || trap_pc !== e.val) begin
      n_bad++; $display("FAIL %s: got redir=%b pc=%h want 1 %h", e.tag, trap_redirect, trap_pc, e.val);
    end
    @(negedge clk); ext_irq = 0; timer_irq = 0; idle();
    sb.push_back('{"both_mcause", A_MCAUSE, 32'h8000_000B});
    sb.push_back('{"both_mepc", A_MEPC, 32'h50});
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_vectored();
    exp_t e;
    logic [31:0] obs;
    csr_write(OP_RW, A_MTVEC, 32'h101);
    csr_write(OP_RW, A_MIE, 32'h800);
    csr_write(OP_RW, A_MSTATUS, 32'h8);
    // ext irq (vectored), illegal, ecall, illegal+ecall: each a one-cycle event then idle.
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk); idle(); instr_valid = 1;
      case (k)
        0: begin pc = 32'h60; ext_irq = 1;
                 sb.push_back('{"vec_ext_pc", 12'h0, 32'h12C});
                 sb.push_back('{"vec_ext_mcause", A_MCAUSE, 32'h8000_000B}); end
        1: begin pc = 32'h80; illegal_instr = 1;
                 sb.push_back('{"illegal_pc", 12'h0, 32'h100});
                 sb.push_back('{"illegal_mcause", A_MCAUSE, 32'h2}); end
        2: begin pc = 32'h90; is_ecall = 1;
                 sb.push_back('{"ecall_pc", 12'h0, 32'h100});
                 sb.push_back('{"ecall_mcause", A_MCAUSE, 32'hB}); end
        default: begin pc = 32'h98; is_ecall = 1; illegal_instr = 1;
                 sb.push_back('{"ill_ecall_pc", 12'h0, 32'h100});
                 sb.push_back('{"ill_ecall_mcause", A_MCAUSE, 32'h2}); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (trap_redirect !== 1'b1 || trap_pc !== e.val) begin
        n_bad++; $display("FAIL %s: got redir=%b pc=%h want 1 %h", e.tag, trap_redirect, trap_pc, e.val);
      end
      @(negedge clk); ext_irq = 0; idle();
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
    sb.push_back('{"ill_ecall_mepc", A_MEPC, 32'h98});
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_mret();
    exp_t e;
    logic [31:0] obs;
    csr_write(OP_RW, A_MTVEC, 32'h100);
    csr_write(OP_RW, A_MEPC, 32'h44);
    csr_write(OP_RW, A_MIE, 32'h80);
    csr_write(OP_RW, A_MSTATUS, 32'h80);
    @(negedge clk); idle(); instr_valid = 1; pc = 32'h8C; timer_irq = 1;
    @(posedge clk); #1; n_cmp++;
    if (trap_redirect !== 1'b0) begin n_bad++; $display("FAIL irq_masked: got redir=%b want 0", trap_redirect); end
    @(negedge clk); idle(); instr_valid = 1; pc = 32'h90; is_mret = 1;
    sb.push_back('{"mret_pc", 12'h0, 32'h44});
    @(posedge clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (trap_redirect !== 1'b1 || flush !== 1'b1 || trap_pc !== e.val) begin
      n_bad++; $display("FAIL %s: got redir=%b flush=%b pc=%h want 1 1 %h", e.tag, trap_redirect, flush, trap_pc, e.val);
    end
    peek(A_MSTATUS, obs); n_cmp++;
    if (obs !== 32'h88) begin n_bad++; $display("FAIL mret_mstatus: got %h want 88", obs); end
    // Stale valid instruction during REDIRECT must not take the pending timer.
    @(negedge clk); idle(); instr_valid = 1; pc = 32'h94;
    @(posedge clk); #1; n_cmp++;
    if (trap_redirect !== 1'b0) begin n_bad++; $display("FAIL redirect_no_sample: got redir=%b want 0", trap_redirect); end
    @(negedge clk); idle(); instr_valid = 1; pc = 32'h44;
    sb.push_back('{"retake_pc", 12'h0, 32'h100});
    @(posedge clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (trap_redirect !== 1'b1 || trap_pc !== e.val) begin
      n_bad++; $display("FAIL %s: got redir=%b pc=%h want 1 %h", e.tag, trap_redirect, trap_pc, e.val);
    end
    @(negedge clk); timer_irq = 0; idle();
    sb.push_back('{"retake_mepc", A_MEPC, 32'h44});
    sb.push_back('{"retake_mcause", A_MCAUSE, 32'h8000_0007});
    sb.push_back('{"retake_mstatus", A_MSTATUS, 32'h80});
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_suppress();
    exp_t e;
    logic [31:0] obs;
    csr_write(OP_RW, A_MSTATUS, 32'h0);
    @(negedge clk); idle(); instr_valid = 1; pc = 32'h70; illegal_instr = 1;
    csr_wr_en = 1; csr_op = OP_RW; csr_addr = A_MTVEC; csr_wdata = 32'hABC;
    sb.push_back('{"suppress_pc", 12'h0, 32'h100});
    @(posedge clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (trap_redirect !== 1'b1 || trap_pc !== e.val) begin
      n_bad++; $display("FAIL %s: got redir=%b pc=%h want 1 %h", e.tag, trap_redirect, trap_pc, e.val);
    end
    @(negedge clk); idle();
    @(negedge clk); instr_valid = 0; illegal_instr = 1; is_ecall = 1;
    csr_wr_en = 1; csr_op = OP_RW; csr_addr = A_MTVEC; csr_wdata = 32'h300;
    @(posedge clk); #1; n_cmp++;
    if (trap_redirect !== 1'b0) begin n_bad++; $display("FAIL bubble_no_trap: got redir=%b want 0", trap_redirect); end
    @(negedge clk); idle();
    sb.push_back('{"suppress_mtvec", A_MTVEC, 32'h100});
    sb.push_back('{"suppress_mepc", A_MEPC, 32'h70});
    sb.push_back('{"suppress_mcause", A_MCAUSE, 32'h2});
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
  endtask

  task automatic test_reset_in_redirect();
    exp_t e;
    logic [31:0] obs;
    @(negedge clk); idle(); instr_valid = 1; pc = 32'hA0; is_ecall = 1;
    sb.push_back('{"pre_rst_pc", 12'h0, 32'h100});
    @(posedge clk); #1;
    e = sb.pop_front(); n_cmp++;
    if (trap_redirect !== 1'b1 || trap_pc !== e.val) begin
      n_bad++; $display("FAIL %s: got redir=%b pc=%h want 1 %h", e.tag, trap_redirect, trap_pc, e.val);
    end
    idle(); #1; rst = 1; #1; n_cmp++;
    if ({trap_redirect, flush, trap_pc} !== 34'h0) begin
      n_bad++; $display("FAIL rst_in_redirect: got redir=%b flush=%b pc=%h want 0 0 0", trap_redirect, flush, trap_pc);
    end
    sb.push_back('{"rst2_mtvec", A_MTVEC, MTVEC_RST});
    sb.push_back('{"rst2_mcause", A_MCAUSE, 32'h0});
    while (sb.size() > 0) begin
      e = sb.pop_front(); @(negedge clk); peek(e.addr, obs); n_cmp++;
      if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, obs, e.val); end
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1; n_cmp++;
    if (trap_redirect !== 1'b0) begin n_bad++; $display("FAIL post_rst_redirect: got %b want 0", trap_redirect); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_csr_ops();
    test_timer_irq();
    test_vectored();
    test_mret();
    test_suppress();
    test_reset_in_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
